alu_arbiter: RTL and testbench

Shares the single-cycle integer ALU (`ALU`) between two requesters: the EX-stage datapath (port 0) and the branch/address-calculation unit (port 1). Round-robin arbitration, valid/ready handshake on each request port, one registered response channel tagged with the winning requester's id. It sits between the pipeline control logic and the ALU instance it owns.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_arbiter_alu.sv | 29 ++
 rtl/alu_arbiter.sv | 102 ++++++++++
 tb/tb_alu_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode definitions for the arbitrated ALU and its clients.
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_ADD      = 3'd0;
    localparam alu_op_t ALU_SUB      = 3'd1;
    localparam alu_op_t ALU_AND      = 3'd2;
    localparam alu_op_t ALU_OR       = 3'd3;
    localparam alu_op_t ALU_SLT      = 3'd4;
    localparam alu_op_t OP_LEGAL_MAX = 3'd4;

    function automatic logic op_is_legal(input alu_op_t op);
        return op <= OP_LEGAL_MAX;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Single-cycle integer ALU: add/sub wrap, bitwise and/or, signed set-less-than.
module ALU
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          op,
    output logic [WIDTH-1:0] aluResult
);

    logic signed_lt;

    assign signed_lt = $signed(a) < $signed(b);

    always_comb begin
        aluResult = '0;
        case (op)
            ALU_ADD: aluResult = a + b;
            ALU_SUB: aluResult = a - b;
            ALU_AND: aluResult = a & b;
            ALU_OR:  aluResult = a | b;
            ALU_SLT: aluResult = {{(WIDTH-1){1'b0}}, signed_lt};
            default: aluResult = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a single
// registered, id-tagged response channel.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  alu_op_t          req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  alu_op_t          req1_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_id,
    output logic             resp_err
);

    // Handshake: a transfer happens on any edge where valid && ready. Requesters
    // hold valid/payload until ready; the response is held while valid && !ready.

    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             resp_id_q, resp_id_d;
    logic             resp_err_q, resp_err_d;
    logic             resp_valid_q, resp_valid_d;
    logic             last_grant_q, last_grant_d;

    logic             slot;
    logic             grant0, grant1;
    logic             accept;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    alu_op_t          alu_op;

    assign slot = !resp_valid_q || resp_ready;

    // On a tie the port that did not win last time gets the ALU.
    assign grant0 = req0_valid && (!req1_valid || last_grant_q);
    assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

    assign req0_ready = rst_n && grant0 && slot;
    assign req1_ready = rst_n && grant1 && slot;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign alu_a  = grant1 ? req1_a  : req0_a;
    assign alu_b  = grant1 ? req1_b  : req0_b;
    assign alu_op = grant1 ? req1_op : req0_op;

    ALU #(.WIDTH(WIDTH)) u_alu (
        .a         (alu_a),
        .b         (alu_b),
        .op        (alu_op),
        .aluResult (alu_result)
    );

    always_comb begin
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        resp_err_d   = resp_err_q;
        resp_valid_d = resp_valid_q;
        last_grant_d = last_grant_q;
        if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_id_d    = grant1;
            last_grant_d = grant1;
            resp_err_d   = !op_is_legal(alu_op);
            resp_data_d  = op_is_legal(alu_op) ? alu_result : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_data_q  <= '0;
            resp_id_q    <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            resp_err_q   <= resp_err_d;
            resp_valid_q <= resp_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign resp_err   = resp_err_q;
    assign resp_valid = resp_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: grant, round-robin, backpressure, slt, illegal op, reset.
module tb_alu_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]       req0_op = 3'd0, req1_op = 3'd0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [WIDTH-1:0] resp_data;
    logic             resp_id;
    logic             resp_err;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_err   (resp_err)
    );

    // Advance to just after the next rising edge; inputs change only here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick();
        tick();
        #1;
        tests_run++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        tests_run++;
        if (resp_valid !== 1'b0 || resp_data !== 32'd0 || resp_id !== 1'b0 || resp_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_resp: got v=%b d=%0d id=%b e=%b want 0 0 0 0",
                     resp_valid, resp_data, resp_id, resp_err);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        req0_a = 32'd15; req0_b = 32'd10; req0_op = 3'd0;
        req0_valid = 1'b1;
        resp_ready = 1'b1;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_ready: got %b want 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        tests_run++;
        if (resp_valid !== 1'b1 || resp_data !== 32'd25 || resp_id !== 1'b0 || resp_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_resp: got v=%b d=%0d id=%b e=%b want 1 25 0 0",
                     resp_valid, resp_data, resp_id, resp_err);
        end
        tick();
        tests_run++;
        if (resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_drain: got resp_valid=%b want 0", resp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic             exp_id;
        logic [WIDTH-1:0] exp_data;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req0_a = 32'd15; req0_b = 32'd10; req0_op = 3'd1;
        req1_a = 32'd15; req1_b = 32'd10; req1_op = 3'd2;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_id   = (i % 2 == 1);
            exp_data = exp_id ? 32'd10 : 32'd5;
            tests_run++;
            if (resp_valid !== 1'b1 || resp_id !== exp_id || resp_data !== exp_data) begin
                tests_failed++;
                $display("FAIL round_robin[%0d]: got v=%b id=%b d=%0d want 1 %b %0d",
                         i, resp_valid, resp_id, resp_data, exp_id, exp_data);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        req1_a = 32'd13; req1_b = 32'd8; req1_op = 3'd3;
        req1_valid = 1'b1;
        resp_ready = 1'b1;
        #1;
        tests_run++;
        if (req1_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_accept: got req1_ready=%b want 1", req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        req0_a = 32'd1; req0_b = 32'd2; req0_op = 3'd0;
        req0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (resp_valid !== 1'b1 || resp_data !== 32'd13 || resp_id !== 1'b1 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%0d id=%b rdy=%b%b want 1 13 1 00",
                         i, resp_valid, resp_data, resp_id, req0_ready, req1_ready);
            end
            tick();
        end
        resp_ready = 1'b1;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release_ready: got req0_ready=%b want 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        tests_run++;
        if (resp_valid !== 1'b1 || resp_data !== 32'd3 || resp_id !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_next: got v=%b d=%0d id=%b want 1 3 0", resp_valid, resp_data, resp_id);
        end
        tick();
    endtask

    task automatic test_slt();
        logic [WIDTH-1:0] va [3];
        logic [WIDTH-1:0] vb [3];
        logic [WIDTH-1:0] ve [3];
        va[0] = 32'd13;         vb[0] = 32'd8;  ve[0] = 32'd0;
        va[1] = 32'd8;          vb[1] = 32'd13; ve[1] = 32'd1;
        va[2] = 32'hFFFF_FFFF;  vb[2] = 32'd1;  ve[2] = 32'd1;
        resp_ready = 1'b1;
        req1_op = 3'd4;
        req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req1_a = va[i];
            req1_b = vb[i];
            tick();
            tests_run++;
            if (resp_valid !== 1'b1 || resp_data !== ve[i] || resp_id !== 1'b1 || resp_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL slt[%0d]: got v=%b d=%0d id=%b e=%b want 1 %0d 1 0",
                         i, resp_valid, resp_data, resp_id, resp_err, ve[i]);
            end
        end
        req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        resp_ready = 1'b1;
        req0_a = 32'd5; req0_b = 32'd3; req0_op = 3'd7;
        req0_valid = 1'b1;
        tick();
        tests_run++;
        if (resp_valid !== 1'b1 || resp_data !== 32'd0 || resp_err !== 1'b1 || resp_id !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_op: got v=%b d=%0d e=%b id=%b want 1 0 1 0",
                     resp_valid, resp_data, resp_err, resp_id);
        end
        req0_op = 3'd0;
        tick();
        tests_run++;
        if (resp_valid !== 1'b1 || resp_data !== 32'd8 || resp_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_followup: got v=%b d=%0d e=%b want 1 8 0",
                     resp_valid, resp_data, resp_err);
        end
        req0_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        // Last accept came from port 0, so only a reset makes port 0 win the next tie.
        resp_ready = 1'b1;
        req0_a = 32'd2; req0_b = 32'd2; req0_op = 3'd0;
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        resp_ready = 1'b0;
        tick();
        tests_run++;
        if (resp_valid !== 1'b1 || resp_data !== 32'd4) begin
            tests_failed++;
            $display("FAIL rstmid_pending: got v=%b d=%0d want 1 4", resp_valid, resp_data);
        end
        req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'd0;
        req1_a = 32'd7; req1_b = 32'd3; req1_op = 3'd1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        resp_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        tick();
        tests_run++;
        if (resp_valid !== 1'b0 || resp_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL rstmid_cleared: got v=%b d=%0d want 0 0", resp_valid, resp_data);
        end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_tie: got rdy=%b%b want 10", req0_ready, req1_ready);
        end
        tick();
        tests_run++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_data !== 32'd2) begin
            tests_failed++;
            $display("FAIL rstmid_first: got v=%b id=%b d=%0d want 1 0 2", resp_valid, resp_id, resp_data);
        end
        tick();
        tests_run++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_data !== 32'd4) begin
            tests_failed++;
            $display("FAIL rstmid_second: got v=%b id=%b d=%0d want 1 1 4", resp_valid, resp_id, resp_data);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_slt();
        test_illegal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
